// File: rtl/usb_fs_tx_pkt_fmt_if.sv
// Byte-level tx path bundle: protocol-engine side (pid/payload/status) and serializer side (byte stream).
// master = packet formatter, slave = the engine/serializer environment around it.
interface usb_fs_tx_pkt_fmt_if;
    logic       link_reset_i;
    logic       tx_pkt_start_i;
    logic [3:0] tx_pid_i;
    logic       tx_data_avail_i;
    logic       tx_data_get_o;
    logic [7:0] tx_data_i;
    logic       tx_pkt_end_o;
    logic       tx_start_err_o;
    logic       tx_abort_o;
    logic       byte_valid_o;
    logic [7:0] byte_o;
    logic       byte_sop_o;
    logic       byte_eop_o;
    logic       byte_ready_i;
    logic       ser_done_i;
    logic       crc_err_o;

    modport master (
        input  link_reset_i, tx_pkt_start_i, tx_pid_i, tx_data_avail_i, tx_data_i,
               byte_ready_i, ser_done_i,
        output tx_data_get_o, tx_pkt_end_o, tx_start_err_o, tx_abort_o,
               byte_valid_o, byte_o, byte_sop_o, byte_eop_o, crc_err_o
    );

    modport slave (
        output link_reset_i, tx_pkt_start_i, tx_pid_i, tx_data_avail_i, tx_data_i,
               byte_ready_i, ser_done_i,
        input  tx_data_get_o, tx_pkt_end_o, tx_start_err_o, tx_abort_o,
               byte_valid_o, byte_o, byte_sop_o, byte_eop_o, crc_err_o
    );
endinterface

// File: rtl/usb_fs_tx_pkt_fmt.sv
// USB FS tx packet formatter: PID + payload + CRC16 bytes to the serializer (USBDEV_TX_CRC_CHECK_EN adds a CRC self-check).
// Latency: first byte valid one cycle after tx_pkt_start_i; payload gets spaced >= GetGapCyc cycles.
// Backpressure: byte_o/sop/eop held while byte_valid_o && !byte_ready_i; no payload fetch while a byte is pending.
module usb_fs_tx_pkt_fmt #(
    parameter int MaxPktSizeByte = 64,
    parameter int GetGapCyc      = 3
) (
    input logic                 clk_48mhz_i,
    input logic                 rst_i,
    usb_fs_tx_pkt_fmt_if.master bus
);
    localparam int PktCntW = $clog2(MaxPktSizeByte + 1);
    localparam int GapW    = (GetGapCyc > 1) ? $clog2(GetGapCyc) : 1;

    typedef enum logic [2:0] {
        StIdle, StPid, StData, StCrcLo, StCrcHi, StWaitDone
    } state_e;

    state_e             state_q;
    logic [3:0]         pid_q;
    logic [15:0]        crc_q;
    logic [PktCntW-1:0] cnt_q;
    logic [GapW-1:0]    gap_q;
    logic               valid_q, sop_q, eop_q;
    logic [7:0]         byte_q;
    logic               get_q, end_q, start_err_q, abort_q;
    logic               xfer;

    // Reflected CRC16 (0xA001), LSB of the byte first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign xfer = valid_q && bus.byte_ready_i;

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pid_q       <= '0;
            crc_q       <= 16'hFFFF;
            cnt_q       <= '0;
            gap_q       <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            byte_q      <= '0;
            get_q       <= 1'b0;
            end_q       <= 1'b0;
            start_err_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            get_q       <= 1'b0;
            end_q       <= 1'b0;
            start_err_q <= 1'b0;
            abort_q     <= 1'b0;
            if (gap_q != '0) gap_q <= gap_q - GapW'(1);

            if (state_q != StIdle && bus.link_reset_i) begin
                state_q <= StIdle;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
                gap_q   <= '0;
                abort_q <= 1'b1;
            end else begin
                if (state_q != StIdle && bus.tx_pkt_start_i) start_err_q <= 1'b1;
                unique case (state_q)
                    StIdle: if (bus.tx_pkt_start_i) begin
                        pid_q   <= bus.tx_pid_i;
                        crc_q   <= 16'hFFFF;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        valid_q <= 1'b1;
                        byte_q  <= {~bus.tx_pid_i, bus.tx_pid_i};
                        sop_q   <= 1'b1;
                        eop_q   <= (bus.tx_pid_i[1:0] != 2'b11);
                        state_q <= StPid;
                    end
                    StPid: if (xfer) begin
                        valid_q <= 1'b0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        state_q <= (pid_q[1:0] == 2'b11) ? StData : StWaitDone;
                    end
                    StData: begin
                        if (valid_q) begin
                            if (xfer) valid_q <= 1'b0;
                        end else if (gap_q == '0) begin
                            if (bus.tx_data_avail_i && cnt_q < PktCntW'(MaxPktSizeByte)) begin
                                byte_q  <= bus.tx_data_i;
                                valid_q <= 1'b1;
                                get_q   <= 1'b1;
                                crc_q   <= crc16_upd(crc_q, bus.tx_data_i);
                                cnt_q   <= cnt_q + PktCntW'(1);
                                gap_q   <= GapW'(GetGapCyc - 1);
                            end else begin
                                byte_q  <= ~crc_q[7:0];
                                valid_q <= 1'b1;
                                state_q <= StCrcLo;
                            end
                        end
                    end
                    StCrcLo: if (xfer) begin
                        byte_q  <= ~crc_q[15:8];
                        eop_q   <= 1'b1;
                        state_q <= StCrcHi;
                    end
                    StCrcHi: if (xfer) begin
                        valid_q <= 1'b0;
                        eop_q   <= 1'b0;
                        state_q <= StWaitDone;
                    end
                    StWaitDone: if (bus.ser_done_i) begin
                        end_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.tx_data_get_o  = get_q;
    assign bus.tx_pkt_end_o   = end_q;
    assign bus.tx_start_err_o = start_err_q;
    assign bus.tx_abort_o     = abort_q;
    assign bus.byte_valid_o   = valid_q;
    assign bus.byte_o         = byte_q;
    assign bus.byte_sop_o     = sop_q;
    assign bus.byte_eop_o     = eop_q;

`ifdef USBDEV_TX_CRC_CHECK_EN
    // Re-runs the CRC over what actually left; a good packet leaves the USB residue.
    logic [15:0] chk_q;
    logic        crc_err_q;

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            chk_q     <= 16'hFFFF;
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= 1'b0;
            if (xfer && !bus.link_reset_i) begin
                unique case (state_q)
                    StPid:   chk_q <= 16'hFFFF;
                    StData:  chk_q <= crc16_upd(chk_q, byte_q);
                    StCrcLo: chk_q <= crc16_upd(chk_q, byte_q);
                    StCrcHi: crc_err_q <= (crc16_upd(chk_q, byte_q) != 16'hB001);
                    default: chk_q <= chk_q;
                endcase
            end
        end
    end

    assign bus.crc_err_o = crc_err_q;
`else
    assign bus.crc_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_usb_fs_tx_pkt_fmt.sv
// Randomised packets against a bit-serial reference model of the USB tx byte stream.
module tb_usb_fs_tx_pkt_fmt;
    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    usb_fs_tx_pkt_fmt_if bus();

    usb_fs_tx_pkt_fmt #(.MaxPktSizeByte(64), .GetGapCyc(3)) dut (
        .clk_48mhz_i(clk),
        .rst_i      (rst),
        .bus        (bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:127];
    int eng_len    = 0;
    int start_gets = 0;
    int get_total  = 0;
    int ready_mode = 2;
    int done_delay = 2;

    logic [9:0] mon_q[$];
    logic [9:0] exp_q[$];
    int get_cyc_q[$];
    int end_cnt = 0, abort_cnt = 0, serr_cnt = 0, crcerr_cnt = 0, stab_viol = 0, cyc = 0;

    // Protocol engine: walks the payload table, one byte per get pulse.
    initial begin : engine
        int k;
        bus.tx_data_i       = 8'h00;
        bus.tx_data_avail_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_data_get_o === 1'b1) get_total++;
            k = get_total - start_gets;
            bus.tx_data_avail_i = (k < eng_len);
            bus.tx_data_i       = (k < eng_len && k < 128) ? pay[k] : 8'h00;
        end
    end

    // Serializer: ready pattern per ready_mode, ser_done done_delay cycles after the eop byte.
    initial begin : serializer
        int   cd;
        logic xe;
        cd = 0;
        bus.byte_ready_i = 1'b0;
        bus.ser_done_i   = 1'b0;
        forever begin
            @(negedge clk);
            xe = bus.byte_valid_o && bus.byte_ready_i && bus.byte_eop_o && !rst && !bus.link_reset_i;
            @(posedge clk); #2;
            bus.ser_done_i = 1'b0;
            if (rst) cd = 0;
            else if (xe) cd = done_delay;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) bus.ser_done_i = 1'b1;
            end
            case (ready_mode)
                0:       bus.byte_ready_i = ($urandom_range(0, 3) != 0);
                1:       bus.byte_ready_i = 1'b0;
                default: bus.byte_ready_i = 1'b1;
            endcase
        end
    end

    logic       pv = 1'b0, pr = 1'b0, plr = 1'b1;
    logic [9:0] pb = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst && pv && !pr && !plr) begin
            if (!(bus.byte_valid_o === 1'b1 && {bus.byte_sop_o, bus.byte_eop_o, bus.byte_o} === pb))
                stab_viol++;
        end
        if (bus.byte_valid_o === 1'b1 && bus.byte_ready_i === 1'b1 && !bus.link_reset_i && !rst)
            mon_q.push_back({bus.byte_sop_o, bus.byte_eop_o, bus.byte_o});
        if (bus.tx_data_get_o === 1'b1)  get_cyc_q.push_back(cyc);
        if (bus.tx_pkt_end_o === 1'b1)   end_cnt++;
        if (bus.tx_abort_o === 1'b1)     abort_cnt++;
        if (bus.tx_start_err_o === 1'b1) serr_cnt++;
        if (bus.crc_err_o === 1'b1)      crcerr_cnt++;
        pv  = bus.byte_valid_o;
        pr  = bus.byte_ready_i;
        plr = bus.link_reset_i || rst;
        pb  = {bus.byte_sop_o, bus.byte_eop_o, bus.byte_o};
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC16 as a non-reflected shift register fed in wire order, reflected and inverted at the end.
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] r, rr;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ pay[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        for (int b = 0; b < 16; b++) rr[b] = r[15-b];
        return ~rr;
    endfunction

    function automatic int exp_gets(input logic [3:0] pid, input int len);
        if (pid[1:0] != 2'b11) return 0;
        return (len > 64) ? 64 : len;
    endfunction

    function automatic void build_exp(input logic [3:0] pid, input int len);
        logic [15:0] c;
        int n;
        exp_q.delete();
        exp_q.push_back({1'b1, (pid[1:0] != 2'b11), ~pid, pid});
        if (pid[1:0] == 2'b11) begin
            n = exp_gets(pid, len);
            for (int i = 0; i < n; i++) exp_q.push_back({2'b00, pay[i]});
            c = model_crc(n);
            exp_q.push_back({2'b00, c[7:0]});
            exp_q.push_back({2'b01, c[15:8]});
        end
    endfunction

    task automatic send_pkt(input logic [3:0] pid, input int len, input int bp_after, input string tag);
        int bb, bg, be, sv0, ng, mind, t;
        bit bp_done;
        logic [9:0] obs;
        eng_len = len; start_gets = get_total;
        step(1);
        bb = mon_q.size(); bg = get_cyc_q.size(); be = end_cnt; sv0 = stab_viol; bp_done = 0;
        bus.tx_pid_i = pid; bus.tx_pkt_start_i = 1'b1;
        step(1);
        bus.tx_pkt_start_i = 1'b0;
        chk({tag, " valid_rise"}, 32'(bus.byte_valid_o), 1);
        for (t = 0; t < 4000 && end_cnt == be; t++) begin
            if (bp_after > 0 && !bp_done && (mon_q.size() - bb) >= bp_after) begin
                ready_mode = 1;
                step(10);
                chk({tag, " bp_valid"}, 32'(bus.byte_valid_o), 1);
                chk({tag, " bp_byte"}, 32'(bus.byte_o), 32'(pay[bp_after-1]));
                ready_mode = 0;
                bp_done = 1;
            end
            step(1);
        end
        chk({tag, " end_seen"}, 32'(end_cnt > be), 1);
        step(3);
        chk({tag, " end_pulses"}, end_cnt - be, 1);
        build_exp(pid, len);
        chk({tag, " nbytes"}, mon_q.size() - bb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (bb + i < mon_q.size()) ? mon_q[bb+i] : 10'h3FF;
            chk($sformatf("%s byte%0d", tag, i), 32'(obs), 32'(exp_q[i]));
        end
        ng = get_cyc_q.size() - bg;
        chk({tag, " gets"}, ng, exp_gets(pid, len));
        mind = 1000;
        for (int i = bg + 1; i < get_cyc_q.size(); i++)
            if (get_cyc_q[i] - get_cyc_q[i-1] < mind) mind = get_cyc_q[i] - get_cyc_q[i-1];
        if (ng > 1) chk({tag, " get_gap"}, 32'(mind >= 3), 1);
        chk({tag, " stable"}, stab_viol - sv0, 0);
    endtask

    initial begin : main
        int bb, bg, be, ae, se, t;
        rst = 1'b1;
        bus.link_reset_i   = 1'b0;
        bus.tx_pkt_start_i = 1'b0;
        bus.tx_pid_i       = 4'h0;
        step(3);
        chk("rst valid", 32'(bus.byte_valid_o), 0);
        chk("rst byte", 32'(bus.byte_o), 0);
        chk("rst sop_eop", 32'({bus.byte_sop_o, bus.byte_eop_o}), 0);
        chk("rst pulses", 32'({bus.tx_data_get_o, bus.tx_pkt_end_o, bus.tx_start_err_o,
                               bus.tx_abort_o, bus.crc_err_o}), 0);
        rst = 1'b0;
        step(2);
        chk("idle valid", 32'(bus.byte_valid_o), 0);

        ready_mode = 2; done_delay = 3;
        send_pkt(4'h2, 0, 0, "ack");
        send_pkt(4'hB, 0, 0, "zlp_data1");
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        ready_mode = 0;
        send_pkt(4'h3, 9, 0, "data0_check");
        chk("data0 crc_lo", 32'(mon_q[mon_q.size()-2]), 32'(10'h0C8));
        chk("data0 crc_hi", 32'(mon_q[mon_q.size()-1]), 32'({2'b01, 8'hB4}));

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 128; i++) pay[i] = 8'($urandom);
            done_delay = $urandom_range(1, 6);
            send_pkt(4'($urandom), $urandom_range(0, 24), 0, $sformatf("rand%0d", r));
        end

        for (int i = 0; i < 128; i++) pay[i] = 8'($urandom);
        send_pkt(4'h3, 20, 5, "backpressure");
        ready_mode = 2;
        send_pkt(4'hB, 70, 0, "limit64");

        // Abort mid-payload
        ready_mode = 0;
        eng_len = 30; start_gets = get_total;
        step(1);
        bg = get_cyc_q.size(); ae = abort_cnt; be = end_cnt;
        bus.tx_pid_i = 4'h3; bus.tx_pkt_start_i = 1'b1;
        step(1);
        bus.tx_pkt_start_i = 1'b0;
        for (t = 0; t < 500 && (get_cyc_q.size() - bg) < 3; t++) step(1);
        chk("abort in_data", 32'((get_cyc_q.size() - bg) >= 3), 1);
        bus.link_reset_i = 1'b1;
        step(1);
        bus.link_reset_i = 1'b0;
        chk("abort valid_low", 32'(bus.byte_valid_o), 0);
        chk("abort pulse", 32'(bus.tx_abort_o), 1);
        bg = get_cyc_q.size();
        step(1);
        chk("abort pulse_end", 32'(bus.tx_abort_o), 0);
        step(10);
        chk("abort count", abort_cnt - ae, 1);
        chk("abort no_end", end_cnt - be, 0);
        chk("abort no_gets", get_cyc_q.size() - bg, 0);
        send_pkt(4'h2, 0, 0, "ack_after_abort");

        // Start while waiting for ser_done
        ready_mode = 2; done_delay = 8;
        eng_len = 0; start_gets = get_total;
        step(1);
        bb = mon_q.size(); be = end_cnt; se = serr_cnt;
        bus.tx_pid_i = 4'h2; bus.tx_pkt_start_i = 1'b1;
        step(1);
        bus.tx_pkt_start_i = 1'b0;
        for (t = 0; t < 100 && mon_q.size() == bb; t++) step(1);
        bus.tx_pid_i = 4'hA; bus.tx_pkt_start_i = 1'b1;
        step(1);
        bus.tx_pkt_start_i = 1'b0;
        chk("busy start_err", 32'(bus.tx_start_err_o), 1);
        for (t = 0; t < 100 && end_cnt == be; t++) step(1);
        step(10);
        chk("busy end", end_cnt - be, 1);
        chk("busy bytes", mon_q.size() - bb, 1);
        chk("busy serr_count", serr_cnt - se, 1);
        chk("busy pid_byte", 32'(mon_q[bb]), 32'({2'b11, 8'hD2}));

        // Reset mid-packet: no abort pulse
        ready_mode = 0;
        eng_len = 20; start_gets = get_total;
        step(1);
        bg = get_cyc_q.size(); ae = abort_cnt;
        bus.tx_pid_i = 4'h3; bus.tx_pkt_start_i = 1'b1;
        step(1);
        bus.tx_pkt_start_i = 1'b0;
        for (t = 0; t < 500 && (get_cyc_q.size() - bg) < 2; t++) step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("rst_mid no_abort", abort_cnt - ae, 0);
        chk("rst_mid valid", 32'(bus.byte_valid_o), 0);
        chk("rst_mid byte", 32'(bus.byte_o), 0);
        send_pkt(4'h3, 4, 0, "after_rst");

        chk("crc_err never", crcerr_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
